// File: rtl/vga_timing_gen.sv
// Parametrised single-clock VGA raster timing generator: counters, sync, blanking,
// framebuffer window decode and line/frame/fetch strobes, all registered.
module vga_timing_gen #(
  parameter int   CW           = 10,
  parameter int   H_TOTAL      = 800,
  parameter int   H_ACT        = 640,
  parameter int   H_SYNC_BEGIN = 656,
  parameter int   H_SYNC_END   = 752,
  parameter int   V_TOTAL      = 525,
  parameter int   V_ACT        = 480,
  parameter int   V_SYNC_BEGIN = 490,
  parameter int   V_SYNC_END   = 492,
  parameter int   WIN_X        = 64,
  parameter int   WIN_W        = 512,
  parameter int   WIN_Y        = 69,
  parameter int   WIN_H        = 342,
  parameter logic H_SYNC_POL   = 1'b0,
  parameter logic V_SYNC_POL   = 1'b0,
  parameter int   FETCH_LEAD   = 8
) (
  input  logic          pixClk,
  input  logic          nReset,
  input  logic          run,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          hSync,
  output logic          vSync,
  output logic          hActive,
  output logic          vActive,
  output logic          de,
  output logic          winActive,
  output logic [CW-1:0] winX,
  output logic [CW-1:0] winY,
  output logic          lineStart,
  output logic          frameStart,
  output logic          fetchReq
);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACT);
  localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACT);
  localparam logic [CW-1:0] H_SB_C     = CW'(H_SYNC_BEGIN);
  localparam logic [CW-1:0] H_SE_C     = CW'(H_SYNC_END);
  localparam logic [CW-1:0] V_SB_C     = CW'(V_SYNC_BEGIN);
  localparam logic [CW-1:0] V_SE_C     = CW'(V_SYNC_END);
  localparam logic [CW-1:0] WIN_X_C    = CW'(WIN_X);
  localparam logic [CW-1:0] WIN_XE_C   = CW'(WIN_X + WIN_W);
  localparam logic [CW-1:0] WIN_Y_C    = CW'(WIN_Y);
  localparam logic [CW-1:0] WIN_YE_C   = CW'(WIN_Y + WIN_H);
  localparam logic [CW-1:0] FETCH_POS  = CW'(WIN_X - FETCH_LEAD);

  logic [CW-1:0] h_count_q, h_count_d;
  logic [CW-1:0] v_count_q, v_count_d;
  logic [CW-1:0] win_x_q, win_x_d;
  logic [CW-1:0] win_y_q, win_y_d;
  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          h_active_q, h_active_d;
  logic          v_active_q, v_active_d;
  logic          de_q, de_d;
  logic          win_active_q, win_active_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          fetch_req_q, fetch_req_d;
  logic          h_wrap;
  logic          win_row;

  // Flags are decoded from the next counter values so every registered output
  // describes the position presented alongside it.
  always_comb begin
    h_wrap    = (h_count_q == H_LAST);
    h_count_d = h_wrap ? '0 : h_count_q + CW'(1);
    v_count_d = v_count_q;
    if (h_wrap) begin
      v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + CW'(1);
    end

    h_sync_d      = (h_count_d >= H_SB_C && h_count_d < H_SE_C) ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_d      = (v_count_d >= V_SB_C && v_count_d < V_SE_C) ? V_SYNC_POL : ~V_SYNC_POL;
    h_active_d    = (h_count_d < H_ACT_C);
    v_active_d    = (v_count_d < V_ACT_C);
    de_d          = h_active_d && v_active_d;
    win_row       = (v_count_d >= WIN_Y_C) && (v_count_d < WIN_YE_C);
    win_active_d  = win_row && (h_count_d >= WIN_X_C) && (h_count_d < WIN_XE_C);
    win_x_d       = '0;
    win_y_d       = '0;
    if (win_active_d) begin
      win_x_d = h_count_d - WIN_X_C;
      win_y_d = v_count_d - WIN_Y_C;
    end
    line_start_d  = (h_count_d == '0);
    frame_start_d = (h_count_d == '0) && (v_count_d == '0);
    fetch_req_d   = win_row && (h_count_d == FETCH_POS);
  end

  // Reset state equals the decode of the last pixel of a frame.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      h_count_q     <= H_LAST;
      v_count_q     <= V_LAST;
      h_sync_q      <= ~H_SYNC_POL;
      v_sync_q      <= ~V_SYNC_POL;
      h_active_q    <= 1'b0;
      v_active_q    <= 1'b0;
      de_q          <= 1'b0;
      win_active_q  <= 1'b0;
      win_x_q       <= '0;
      win_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      fetch_req_q   <= 1'b0;
    end else if (run) begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      de_q          <= de_d;
      win_active_q  <= win_active_d;
      win_x_q       <= win_x_d;
      win_y_q       <= win_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      fetch_req_q   <= fetch_req_d;
    end
  end

  assign hCount     = h_count_q;
  assign vCount     = v_count_q;
  assign hSync      = h_sync_q;
  assign vSync      = v_sync_q;
  assign hActive    = h_active_q;
  assign vActive    = v_active_q;
  assign de         = de_q;
  assign winActive  = win_active_q;
  assign winX       = win_x_q;
  assign winY       = win_y_q;
  assign lineStart  = line_start_q;
  assign frameStart = frame_start_q;
  assign fetchReq   = fetch_req_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets driven in lockstep and compared
// every clock against a linear-pixel-index reference model.
module tb_vga_timing_gen;

  // Small frame with inverted sync polarity and window touching the active edges
  localparam int S_HT = 48, S_HA = 32, S_HSB = 36, S_HSE = 42;
  localparam int S_VT = 20, S_VA = 14, S_VSB = 15, S_VSE = 17;
  localparam int S_WX = 8, S_WW = 24, S_WY = 3, S_WH = 11, S_FL = 8;
  // Alternate mode
  localparam int A_HT = 1056, A_HA = 800, A_HSB = 840, A_HSE = 968;
  localparam int A_VT = 628, A_VA = 600, A_VSB = 601, A_VSE = 605;
  localparam int A_WX = 144, A_WW = 512, A_WY = 129, A_WH = 342, A_FL = 8;

  typedef struct packed {
    logic [15:0] h, v, wx, wy;
    logic hs, vs, ha, va, de, wa, ls, fs, fr;
  } obs_t;

  typedef struct {
    int ht, ha, hsb, hse, vt, va, vsb, vse, wx, ww, wy, wh, fl;
    logic hp, vp;
  } cfg_t;

  // ---------------- clock / reset ----------------
  logic pixClk = 1'b0;
  logic nReset = 1'b1;
  logic run = 1'b0;
  always #5 pixClk = ~pixClk;

  logic [9:0]  d_h, d_v, d_wx, d_wy;
  logic        d_hs, d_vs, d_ha, d_va, d_de, d_wa, d_ls, d_fs, d_fr;
  logic [5:0]  s_h, s_v, s_wx, s_wy;
  logic        s_hs, s_vs, s_ha, s_va, s_de, s_wa, s_ls, s_fs, s_fr;
  logic [10:0] a_h, a_v, a_wx, a_wy;
  logic        a_hs, a_vs, a_ha, a_va, a_de, a_wa, a_ls, a_fs, a_fr;

  vga_timing_gen u_def (
    .pixClk(pixClk), .nReset(nReset), .run(run),
    .hCount(d_h), .vCount(d_v), .hSync(d_hs), .vSync(d_vs),
    .hActive(d_ha), .vActive(d_va), .de(d_de), .winActive(d_wa),
    .winX(d_wx), .winY(d_wy), .lineStart(d_ls), .frameStart(d_fs), .fetchReq(d_fr)
  );

  vga_timing_gen #(
    .CW(6), .H_TOTAL(S_HT), .H_ACT(S_HA), .H_SYNC_BEGIN(S_HSB), .H_SYNC_END(S_HSE),
    .V_TOTAL(S_VT), .V_ACT(S_VA), .V_SYNC_BEGIN(S_VSB), .V_SYNC_END(S_VSE),
    .WIN_X(S_WX), .WIN_W(S_WW), .WIN_Y(S_WY), .WIN_H(S_WH),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .FETCH_LEAD(S_FL)
  ) u_small (
    .pixClk(pixClk), .nReset(nReset), .run(run),
    .hCount(s_h), .vCount(s_v), .hSync(s_hs), .vSync(s_vs),
    .hActive(s_ha), .vActive(s_va), .de(s_de), .winActive(s_wa),
    .winX(s_wx), .winY(s_wy), .lineStart(s_ls), .frameStart(s_fs), .fetchReq(s_fr)
  );

  vga_timing_gen #(
    .CW(11), .H_TOTAL(A_HT), .H_ACT(A_HA), .H_SYNC_BEGIN(A_HSB), .H_SYNC_END(A_HSE),
    .V_TOTAL(A_VT), .V_ACT(A_VA), .V_SYNC_BEGIN(A_VSB), .V_SYNC_END(A_VSE),
    .WIN_X(A_WX), .WIN_W(A_WW), .WIN_Y(A_WY), .WIN_H(A_WH),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .FETCH_LEAD(A_FL)
  ) u_alt (
    .pixClk(pixClk), .nReset(nReset), .run(run),
    .hCount(a_h), .vCount(a_v), .hSync(a_hs), .vSync(a_vs),
    .hActive(a_ha), .vActive(a_va), .de(a_de), .winActive(a_wa),
    .winX(a_wx), .winY(a_wy), .lineStart(a_ls), .frameStart(a_fs), .fetchReq(a_fr)
  );

  // ---------------- reference model ----------------
  cfg_t c_def, c_small, c_alt;
  int   p_def, p_small, p_alt;
  int   n_checks = 0;
  int   n_err = 0;
  int   n_ticks = 0;

  function automatic int total(cfg_t c);
    return c.ht * c.vt;
  endfunction

  // Expected outputs for linear pixel index p within a frame
  function automatic obs_t model(cfg_t c, int p);
    obs_t e;
    int   h, v;
    logic row;
    h     = p % c.ht;
    v     = p / c.ht;
    row   = (v >= c.wy) && (v < c.wy + c.wh);
    e.h   = 16'(h);
    e.v   = 16'(v);
    e.hs  = (h >= c.hsb && h < c.hse) ? c.hp : ~c.hp;
    e.vs  = (v >= c.vsb && v < c.vse) ? c.vp : ~c.vp;
    e.ha  = (h < c.ha);
    e.va  = (v < c.va);
    e.de  = e.ha && e.va;
    e.wa  = row && (h >= c.wx) && (h < c.wx + c.ww);
    e.wx  = e.wa ? 16'(h - c.wx) : 16'd0;
    e.wy  = e.wa ? 16'(v - c.wy) : 16'd0;
    e.ls  = (h == 0);
    e.fs  = (p == 0);
    e.fr  = row && (h == c.wx - c.fl);
    return e;
  endfunction

  function automatic obs_t obs_def();
    return {16'(d_h), 16'(d_v), 16'(d_wx), 16'(d_wy),
            d_hs, d_vs, d_ha, d_va, d_de, d_wa, d_ls, d_fs, d_fr};
  endfunction
  function automatic obs_t obs_small();
    return {16'(s_h), 16'(s_v), 16'(s_wx), 16'(s_wy),
            s_hs, s_vs, s_ha, s_va, s_de, s_wa, s_ls, s_fs, s_fr};
  endfunction
  function automatic obs_t obs_alt();
    return {16'(a_h), 16'(a_v), 16'(a_wx), 16'(a_wy),
            a_hs, a_vs, a_ha, a_va, a_de, a_wa, a_ls, a_fs, a_fr};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk_obs(string tag, obs_t o, obs_t e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s tick=%0d observed=%h expected=%h", tag, n_ticks, o, e);
    end
  endtask

  task automatic chk_int(string tag, int o, int e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic check_all();
    chk_obs("def", obs_def(), model(c_def, p_def));
    chk_obs("small", obs_small(), model(c_small, p_small));
    chk_obs("alt", obs_alt(), model(c_alt, p_alt));
  endtask

  // Event bookkeeping for directed period/width checks
  int   fs_ticks[$];
  logic cnt_en = 1'b0;
  int   hs_cnt = 0;
  int   vs_cnt = 0;
  int   fr68 = 0;
  int   fr69_cnt = 0;
  int   fr69_h = -1;

  // ---------------- driver ----------------
  task automatic tick();
    logic adv;
    adv = nReset && run;
    @(posedge pixClk);
    #1;
    n_ticks++;
    if (adv) begin
      p_def   = (p_def + 1) % total(c_def);
      p_small = (p_small + 1) % total(c_small);
      p_alt   = (p_alt + 1) % total(c_alt);
    end
    check_all();
    if (adv) begin
      if (s_fs) fs_ticks.push_back(n_ticks);
      if (cnt_en && s_hs) hs_cnt++;
      if (cnt_en && s_vs) vs_cnt++;
      if (d_fr && d_v == 10'd68) fr68++;
      if (d_fr && d_v == 10'd69) begin
        fr69_cnt++;
        fr69_h = int'(d_h);
      end
    end
  endtask

  task automatic set_reset_model();
    p_def   = total(c_def) - 1;
    p_small = total(c_small) - 1;
    p_alt   = total(c_alt) - 1;
  endtask

  initial begin
    c_def   = '{800, 640, 656, 752, 525, 480, 490, 492, 64, 512, 69, 342, 8, 1'b0, 1'b0};
    c_small = '{S_HT, S_HA, S_HSB, S_HSE, S_VT, S_VA, S_VSB, S_VSE,
                S_WX, S_WW, S_WY, S_WH, S_FL, 1'b1, 1'b1};
    c_alt   = '{A_HT, A_HA, A_HSB, A_HSE, A_VT, A_VA, A_VSB, A_VSE,
                A_WX, A_WW, A_WY, A_WH, A_FL, 1'b0, 1'b0};
    set_reset_model();

    // Reset asserted before any clock edge
    #1 nReset = 1'b0;
    #2;
    check_all();
    chk_int("rst_hcount", int'(d_h), 799);
    chk_int("rst_vcount", int'(d_v), 524);
    run = 1'b1;
    repeat (3) tick();

    // Release: first run clock is pixel (0,0)
    nReset = 1'b1;
    cnt_en = 1'b1;
    tick();
    chk_int("first_h", int'(d_h), 0);
    chk_int("first_v", int'(d_v), 0);
    chk_int("first_fs", int'(d_fs), 1);
    chk_int("first_de", int'(d_de), 1);
    for (int k = 2; k <= 960; k++) begin
      tick();
      if (k == 801) begin
        chk_int("line1_v", int'(d_v), 1);
        chk_int("line1_ls", int'(d_ls), 1);
      end
    end
    cnt_en = 1'b0;
    chk_int("small_hsync_clks", hs_cnt, (S_HSE - S_HSB) * S_VT);
    chk_int("small_vsync_clks", vs_cnt, (S_VSE - S_VSB) * S_HT);

    repeat (960) tick();
    chk_int("fs_count_2frames", fs_ticks.size(), 2);
    if (fs_ticks.size() >= 2) chk_int("small_frame_period", fs_ticks[1] - fs_ticks[0], 960);

    // Pause for 37 clocks mid-line on the small frame
    for (int k = 0; k < 200 && s_h != 6'd20; k++) tick();
    chk_int("pause_pos", int'(s_h), 20);
    run = 1'b0;
    repeat (37) tick();
    chk_int("pause_hold", int'(s_h), 20);
    run = 1'b1;
    tick();
    chk_int("pause_resume", int'(s_h), 21);
    for (int k = 0; k < 3000 && fs_ticks.size() < 4; k++) tick();
    chk_int("fs_count_pause", fs_ticks.size(), 4);
    if (fs_ticks.size() >= 4) chk_int("stretched_period", fs_ticks[3] - fs_ticks[2], 997);

    // Random run gating until the default frame reaches line 70
    for (int k = 0; k < 72000 && p_def < 70 * 800; k++) begin
      run = ($urandom_range(0, 7) != 0);
      tick();
    end
    run = 1'b1;
    chk_int("reach_line70", int'(d_v), 70);
    chk_int("fetch_line69_h", fr69_h, 56);
    chk_int("fetch_line69_cnt", fr69_cnt, 1);
    chk_int("fetch_line68_cnt", fr68, 0);

    // Asynchronous reset mid-frame, no clock edge needed
    nReset = 1'b0;
    #2;
    set_reset_model();
    check_all();
    chk_int("async_rst_h", int'(d_h), 799);
    chk_int("async_rst_hs", int'(d_hs), 1);
    chk_int("async_rst_small_hs", int'(s_hs), 0);
    tick();
    nReset = 1'b1;
    tick();
    chk_int("post_rst_h", int'(d_h), 0);
    chk_int("post_rst_fs", int'(d_fs), 1);
    chk_int("post_rst_alt_fs", int'(a_fs), 1);
    for (int k = 0; k < 200; k++) begin
      run = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
